// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with selectable standard/FWFT read mode,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_ctl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_LIM = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LIM = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    always_comb begin
        count        = wr_ptr - rd_ptr;
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        almost_full  = (count >= AF_LIM);
        almost_empty = (count <= AE_LIM);
        wr_ok        = wr_en && !full;
        rd_ok        = rd_en && !empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            overflow  <= (overflow  && !clr_err) || (wr_en && full);
            underflow <= (underflow && !clr_err) || (rd_en && empty);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            always_comb begin
                data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];
                valid    = !empty;
            end
        end else begin : g_std
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_out <= '0;
                    valid    <= 1'b0;
                end else begin
                    valid <= rd_ok;
                    if (rd_ok) data_out <= mem[rd_ptr[AW-1:0]];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Bench for sync_fifo_ctl: standard and FWFT instances on shared stimulus,
// checked every cycle against a queue-based model plus directed literals.
module tb_sync_fifo_ctl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic             clr_err;

    logic [WIDTH-1:0] dout0, dout1;
    logic             valid0, valid1, full0, full1, empty0, empty1;
    logic             af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [4:0]       cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    sync_fifo_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
        .data_out(dout0), .valid(valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
        .data_out(dout1), .valid(valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue plus the standard-mode output register.
    logic [WIDTH-1:0] q[$];
    logic             m_ovf, m_unf, m_v;
    logic [WIDTH-1:0] m_d;

    always @(posedge clk or negedge rst) begin
        int  n;
        bit  wok, rok;
        if (!rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_v   = 1'b0;
            m_d   = '0;
        end else begin
            n     = q.size();
            wok   = wr_en && (n < DEPTH);
            rok   = rd_en && (n > 0);
            m_ovf = (m_ovf && !clr_err) || (wr_en && n == DEPTH);
            m_unf = (m_unf && !clr_err) || (rd_en && n == 0);
            if (rok) begin
                m_d = q.pop_front();
                m_v = 1'b1;
            end else begin
                m_v = 1'b0;
            end
            if (wok) q.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        int n;
        n = q.size();
        chk("count_std",  32'(cnt0), 32'(n));
        chk("count_fwft", 32'(cnt1), 32'(n));
        chk("full_std",   32'(full0),  32'(n == DEPTH));
        chk("full_fwft",  32'(full1),  32'(n == DEPTH));
        chk("empty_std",  32'(empty0), 32'(n == 0));
        chk("empty_fwft", 32'(empty1), 32'(n == 0));
        chk("af_std",     32'(af0), 32'(n >= AF));
        chk("af_fwft",    32'(af1), 32'(n >= AF));
        chk("ae_std",     32'(ae0), 32'(n <= AE));
        chk("ae_fwft",    32'(ae1), 32'(n <= AE));
        chk("ovf_std",    32'(ovf0), 32'(m_ovf));
        chk("ovf_fwft",   32'(ovf1), 32'(m_ovf));
        chk("unf_std",    32'(unf0), 32'(m_unf));
        chk("unf_fwft",   32'(unf1), 32'(m_unf));
        chk("valid_std",  32'(valid0), 32'(m_v));
        chk("dout_std",   32'(dout0),  32'(m_d));
        chk("valid_fwft", 32'(valid1), 32'(n > 0));
        if (n > 0) chk("dout_fwft", 32'(dout1), 32'(q[0]));
    end

    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw, pr;
        rst = 1'b0; wr_en = 1'b0; data_in = '0; rd_en = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_empty", 32'(empty0), 32'd1);
        chk("reset_ae",    32'(ae0),    32'd1);
        chk("reset_count", 32'(cnt0),   32'd0);
        rst = 1'b1;
        cyc(0, 8'h00, 0, 0);

        // Fill, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 8'(i), 0, 0);
            if (i == 12) chk("af_at13", 32'(af0), 32'd0);
            if (i == 13) chk("af_at14", 32'(af0), 32'd1);
        end
        chk("fill_count", 32'(cnt0),  32'd16);
        chk("fill_full",  32'(full0), 32'd1);
        cyc(1, 8'hFF, 0, 0);
        chk("ovf_set",     32'(ovf0), 32'd1);
        chk("ovf_count",   32'(cnt0), 32'd16);

        // Drain in order, then underflow.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 8'h00, 1, 0);
            chk("drain_dout",  32'(dout0),  32'(i));
            chk("drain_valid", 32'(valid0), 32'd1);
            if (i == 13) chk("ae_at2", 32'(ae0), 32'd1);
            if (i == 12) chk("ae_at3", 32'(ae0), 32'd0);
        end
        cyc(0, 8'h00, 0, 0);
        chk("drain_empty", 32'(empty0), 32'd1);
        chk("idle_valid",  32'(valid0), 32'd0);
        cyc(0, 8'h00, 1, 0);
        chk("unf_set",  32'(unf0),  32'd1);
        chk("unf_hold", 32'(dout0), 32'h0F);
        cyc(0, 8'h00, 0, 1);
        chk("clr_ovf", 32'(ovf0), 32'd0);
        chk("clr_unf", 32'(unf0), 32'd0);

        // Steady-state at count=5 across two pointer wraps.
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 40; i++) cyc(1, 8'(8'h40 + i), 1, 0);
        chk("stream_count", 32'(cnt0), 32'd5);
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);

        // Simultaneous read/write at full and at empty.
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h60 + i), 0, 0);
        cyc(1, 8'h77, 1, 0);
        chk("full_rw_count", 32'(cnt0), 32'd15);
        chk("full_rw_ovf",   32'(ovf0), 32'd1);
        for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h55, 1, 0);
        chk("empty_rw_count", 32'(cnt0), 32'd1);
        chk("empty_rw_unf",   32'(unf0), 32'd1);
        cyc(0, 8'h00, 0, 1);
        chk("clr2_ovf", 32'(ovf0), 32'd0);
        chk("clr2_unf", 32'(unf0), 32'd0);
        cyc(0, 8'h00, 1, 0);

        // FWFT zero-latency presentation.
        cyc(1, 8'hA5, 0, 0);
        chk("fwft_dout",  32'(dout1),  32'hA5);
        chk("fwft_valid", 32'(valid1), 32'd1);
        chk("fwft_empty", 32'(empty1), 32'd0);
        cyc(0, 8'h00, 1, 0);
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        chk("fwft_pop_valid", 32'(valid1), 32'd0);

        // Randomized traffic with varying write/read bias.
        for (int seg = 0; seg < 10; seg++) begin
            pw = $urandom_range(85, 15);
            pr = $urandom_range(85, 15);
            for (int i = 0; i < 200; i++)
                cyc(($urandom_range(99) < pw), 8'($urandom), ($urandom_range(99) < pr),
                    ($urandom_range(99) < 3));
        end

        // Asynchronous reset mid-stream at count=9.
        cyc(0, 8'h00, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 9; i++) cyc(1, 8'(8'h90 + i), (i == 0), 0);
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h99, 0, 0);
        chk("pre_rst_count", 32'(cnt0), 32'd9);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count",  32'(cnt0),   32'd0);
        chk("arst_empty",  32'(empty0), 32'd1);
        chk("arst_full",   32'(full0),  32'd0);
        chk("arst_af",     32'(af0),    32'd0);
        chk("arst_ae",     32'(ae0),    32'd1);
        chk("arst_valid",  32'(valid0), 32'd0);
        chk("arst_dout",   32'(dout0),  32'd0);
        chk("arst_valid1", 32'(valid1), 32'd0);
        chk("arst_ovf",    32'(ovf0),   32'd0);
        chk("arst_unf",    32'(unf0),   32'd0);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 8'h3C, 0, 0);
        chk("post_rst_fwft", 32'(dout1), 32'h3C);
        cyc(0, 8'h00, 1, 0);
        chk("post_rst_dout",  32'(dout0),  32'h3C);
        chk("post_rst_valid", 32'(valid0), 32'd1);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Parametrised single-clock FIFO: the next generation of the team's synchronous FIFO, for buffering between producer and consumer blocks in the same clock domain. Adds a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with software clear. Occupancy count is sized from DEPTH instead of a fixed width.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- FWFT, 0, 0 = standard mode (registered read, 1-cycle latency); 1 = first-word-fall-through
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- data_in  in  WIDTH  write data
- rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
- clr_err  in  1  clears overflow and underflow
- data_out  out  WIDTH  read data
- valid  out  1  standard mode: data_out updated by the previous edge; FWFT: equals !empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x WIDTH array, not reset. wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; the low bits address the array; wrap is natural modulo 2·DEPTH.
- full: pointers' low bits equal and MSBs differ. empty: pointers equal. count = wr_ptr − rd_ptr (registered, or derived identically from registered pointers).
- Write accepted iff wr_en && !full (pre-edge flag): mem[wr_ptr] ← data_in, wr_ptr+1.
- Read accepted iff rd_en && !empty (pre-edge flag): rd_ptr+1.
- Both accepted in one cycle: count unchanged. When full, a simultaneous read does NOT make room for the write: write rejected, overflow set. When empty, write accepted, read rejected, underflow set.
- Standard mode (FWFT=0): on an accepted read, data_out ← mem[rd_ptr] at that edge and valid=1 for the following cycle; otherwise valid=0 and data_out holds its value.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] combinationally whenever !empty (don't-care when empty); valid = !empty; rd_en pops the presented word.
- overflow ← 1 on wr_en && full; underflow ← 1 on rd_en && empty. clr_err clears both; if a new error occurs in the same cycle as clr_err, set wins.
- almost_full/almost_empty: combinational compares on count; no hysteresis.

## Timing
- Reset (asserted at any time, including mid-transfer): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? n/a : 0), valid=0, data_out=0, overflow=0, underflow=0. Outputs take reset values immediately, without waiting for a clock edge. Array contents are retained but unreachable.
- Write at edge N: count, empty, full, almost_* reflect it after edge N. FWFT: word on data_out, valid=1 after edge N (0-cycle latency after the write edge).
- Standard read accepted at edge N: data_out/valid valid from edge N until edge N+1.
- Flags are all derived from registered state; no combinational path from wr_en/rd_en to any flag. FWFT data_out depends only on rd_ptr and the array.
- Pointer wrap at DEPTH and 2·DEPTH is invisible at the ports: count and flags stay correct across any number of wraps.

## Test plan
- Reset then DEPTH=16, FWFT=0: write 0x00..0x0F on 16 cycles -> full=1, count=16, almost_full=1 from count=14; 17th write -> rejected, overflow=1, count=16.
- From full, read 16 times -> data_out 0x00..0x0F in order, each with valid=1 one cycle after its read edge; then empty=1, almost_empty=1 at count ≤2; extra read -> underflow=1, data_out holds 0x0F.
- Simultaneous wr_en+rd_en at count=5 for 40 cycles (crosses pointer wrap twice) -> count stays 5, output sequence matches write order.
- Simultaneous wr_en+rd_en when full -> read accepted, write dropped, count=15, overflow=1. Same when empty -> count=1, underflow=1. Then clr_err for 1 cycle -> both flags 0.
- FWFT=1: write 0xA5 into empty FIFO at edge N -> data_out=0xA5, valid=1, empty=0 after edge N with no rd_en; rd_en pop -> empty=1, valid=0.
- Assert rst low mid-stream with count=9 between edges -> all outputs at reset values immediately; after release, a write of 0x3C then read returns 0x3C, not stale data.
